vedic_pp_combine: RTL and testbench

- Final reduction stage of the 64x64 Vedic multiplier.
- Consumes the four 64-bit partial products from the 32x32 Vedic sub-multipliers and produces the registered 128-bit product.
- Computes P = Q0 + ((Q1 + Q2) << 32) + (Q3 << 64) in a 2-stage valid/ready pipeline.
- All additions are built from rca_32bit slices.

---
 rtl/vedic_pp_combine_if.sv | 23 ++
 rtl/vedic_pp_combine.sv | 116 +++++++++++
 tb/tb_vedic_pp_combine.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_pp_combine_if.sv
// Partial-product in / product out bus for the 64x64 Vedic multiplier final reduction stage.
// Includes valid/ready handshakes on both sides.
interface vedic_pp_combine_if;
  logic [63:0]  Q0;
  logic [63:0]  Q1;
  logic [63:0]  Q2;
  logic [63:0]  Q3;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] P;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output Q0, Q1, Q2, Q3, in_valid, out_ready,
    input  in_ready, P, out_valid
  );

  modport slave (
    input  Q0, Q1, Q2, Q3, in_valid, out_ready,
    output in_ready, P, out_valid
  );
endinterface

// File: rtl/vedic_pp_combine.sv
// Final reduction of the 64x64 Vedic multiplier: P = Q0 + ((Q1+Q2) << 32) + (Q3 << 64).
// Two-stage valid/ready pipeline built from chained 32-bit ripple-carry adders.
module vedic_pp_combine #(
  parameter bit USE_RCA = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  vedic_pp_combine_if.slave  bus
);
  localparam int unsigned QW  = 64;
  localparam int unsigned MW  = 65;
  localparam int unsigned HW  = 96;
  localparam int unsigned HCW = 97;
  localparam int unsigned PW  = 128;

  logic [MW-1:0] mid_c;
  logic [HW-1:0] hi_a_c, hi_b_c, hi_sum_c;
  logic          unused_cout;
  logic          s1_en_c, s2_en_c;

  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] mid_q, mid_d;
  logic [QW-1:0] q0_q, q0_d;
  logic [QW-1:0] q3_q, q3_d;
  logic [PW-1:0] p_q, p_d;
  logic          out_valid_q, out_valid_d;

  assign hi_a_c = {q3_q, q0_q[63:32]};
  assign hi_b_c = HW'(mid_q);

  generate
    if (USE_RCA) begin : g_rca
      logic       c_mid;
      logic [1:0] c_hi;
      rca_32bit u_mid_lo (.a(bus.Q1[31:0]),  .b(bus.Q2[31:0]),  .cin(1'b0),  .sum(mid_c[31:0]),  .cout(c_mid));
      rca_32bit u_mid_hi (.a(bus.Q1[63:32]), .b(bus.Q2[63:32]), .cin(c_mid), .sum(mid_c[63:32]), .cout(mid_c[64]));
      rca_32bit u_hi_0 (.a(hi_a_c[31:0]),  .b(hi_b_c[31:0]),  .cin(1'b0),    .sum(hi_sum_c[31:0]),  .cout(c_hi[0]));
      rca_32bit u_hi_1 (.a(hi_a_c[63:32]), .b(hi_b_c[63:32]), .cin(c_hi[0]), .sum(hi_sum_c[63:32]), .cout(c_hi[1]));
      rca_32bit u_hi_2 (.a(hi_a_c[95:64]), .b(hi_b_c[95:64]), .cin(c_hi[1]), .sum(hi_sum_c[95:64]), .cout(unused_cout));
    end else begin : g_beh
      assign mid_c = MW'(bus.Q1) + MW'(bus.Q2);
      assign {unused_cout, hi_sum_c} = HCW'(hi_a_c) + HCW'(hi_b_c);
    end
  endgenerate

  // Stage 2 frees when its product leaves; stage 1 frees when empty or stage 2 advances.
  assign s2_en_c = !out_valid_q || bus.out_ready;
  assign s1_en_c = !s1_valid_q || s2_en_c;

  assign bus.in_ready  = s1_en_c;
  assign bus.P         = p_q;
  assign bus.out_valid = out_valid_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    mid_d       = mid_q;
    q0_d        = q0_q;
    q3_d        = q3_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    if (s2_en_c) begin
      p_d         = {hi_sum_c, q0_q[31:0]};
      out_valid_d = s1_valid_q;
    end
    if (s1_en_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        mid_d = mid_c;
        q0_d  = bus.Q0;
        q3_d  = bus.Q3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      mid_q       <= '0;
      q0_q        <= '0;
      q3_q        <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      mid_q       <= mid_d;
      q0_q        <= q0_d;
      q3_q        <= q3_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// 32-bit ripple-carry adder slice; chain cout->cin for wider sums.
module rca_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  localparam int unsigned RW = 32;

  logic [RW:0] c_c;

  always_comb begin
    c_c    = '0;
    sum    = '0;
    c_c[0] = cin;
    for (int unsigned i = 0; i < RW; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_c[i];
      c_c[i+1] = (a[i] & b[i]) | (c_c[i] & (a[i] ^ b[i]));
    end
    cout = c_c[RW];
  end
endmodule

// File: tb/tb_vedic_pp_combine.sv
// Directed bench for vedic_pp_combine: ripple-carry and behavioural builds run side by side.
module tb_vedic_pp_combine;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  vedic_pp_combine_if bus_a ();
  vedic_pp_combine_if bus_b ();

  assign bus_b.Q0        = bus_a.Q0;
  assign bus_b.Q1        = bus_a.Q1;
  assign bus_b.Q2        = bus_a.Q2;
  assign bus_b.Q3        = bus_a.Q3;
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.out_ready = bus_a.out_ready;

  vedic_pp_combine #(.USE_RCA(1'b1)) u_dut_rca (.clk(clk), .rst(rst), .bus(bus_a));
  vedic_pp_combine #(.USE_RCA(1'b0)) u_dut_beh (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] d);
    bus_a.in_valid = v;
    bus_a.Q0 = a;
    bus_a.Q1 = b;
    bus_a.Q2 = c;
    bus_a.Q3 = d;
  endtask

  function automatic logic [127:0] model(input logic [63:0] q0, input logic [63:0] q1,
                                         input logic [63:0] q2, input logic [63:0] q3);
    logic [127:0] r;
    r = {64'b0, q0} + ({64'b0, q1} << 32) + ({64'b0, q2} << 32) + ({64'b0, q3} << 64);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus_a.out_ready = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    #1;
    tests_run++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b/%b want 0", bus_a.out_valid, bus_b.out_valid);
    end
    tests_run++;
    if (bus_a.P !== 128'd0 || bus_b.P !== 128'd0) begin
      tests_failed++; $display("FAIL reset_P: got %h/%h want 0", bus_a.P, bus_b.P);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b/%b want 1", bus_a.in_ready, bus_b.in_ready);
    end
  endtask

  // One product through an idle pipeline with out_ready held high.
  task automatic send_one(input string name, input logic [63:0] q0, input logic [63:0] q1,
                          input logic [63:0] q2, input logic [63:0] q3, input logic [127:0] exp);
    bus_a.out_ready = 1'b1;
    drive(1'b1, q0, q1, q2, q3);
    tick();
    drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    tests_run++;
    if (bus_a.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL %s_early_valid: got %b want 0", name, bus_a.out_valid);
    end
    tick();
    tests_run++;
    if (bus_a.out_valid !== 1'b1 || bus_b.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL %s_valid: got %b/%b want 1", name, bus_a.out_valid, bus_b.out_valid);
    end
    tests_run++;
    if (bus_a.P !== exp) begin
      tests_failed++; $display("FAIL %s_P_rca: got %h want %h", name, bus_a.P, exp);
    end
    tests_run++;
    if (bus_b.P !== exp) begin
      tests_failed++; $display("FAIL %s_P_beh: got %h want %h", name, bus_b.P, exp);
    end
    tick();
    tests_run++;
    if (bus_a.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL %s_late_valid: got %b want 0", name, bus_a.out_valid);
    end
  endtask

  task automatic test_identity();
    send_one("identity", 64'd1, 64'd0, 64'd0, 64'd0, 128'd1);
  endtask

  task automatic test_mid_carry();
    send_one("mid_carry", 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,
             128'h00000001_00000000_00000000_00000000);
  endtask

  task automatic test_max_operands();
    send_one("max_ops", 64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000001,
             64'hFFFFFFFE_00000001, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
  endtask

  task automatic test_back_to_back();
    logic [63:0]  qs [8][4];
    logic [127:0] exp [8];
    int got;
    int first;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) qs[i][j] = {$urandom, $urandom};
      exp[i] = model(qs[i][0], qs[i][1], qs[i][2], qs[i][3]);
    end
    got = 0;
    first = -1;
    bus_a.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, qs[cyc][0], qs[cyc][1], qs[cyc][2], qs[cyc][3]);
      else drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
      #1;
      if (cyc < 8) begin
        tests_run++;
        if (bus_a.in_ready !== 1'b1) begin
          tests_failed++; $display("FAIL stream_in_ready[%0d]: got %b want 1", cyc, bus_a.in_ready);
        end
      end
      if (bus_a.out_valid === 1'b1 && got < 8) begin
        if (first < 0) first = cyc;
        tests_run++;
        if (cyc != first + got) begin
          tests_failed++; $display("FAIL stream_gap: output %0d at cycle %0d want %0d", got, cyc, first + got);
        end
        tests_run++;
        if (bus_a.P !== exp[got] || bus_b.P !== exp[got]) begin
          tests_failed++; $display("FAIL stream_P[%0d]: got %h/%h want %h", got, bus_a.P, bus_b.P, exp[got]);
        end
        got++;
      end
      tick();
    end
    tests_run++;
    if (got != 8 || first != 2) begin
      tests_failed++; $display("FAIL stream_count: got %0d outputs first at %0d want 8 first at 2", got, first);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0]  qs [4][4];
    logic [127:0] exp [4];
    int acc;
    int got;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) qs[i][j] = {$urandom, $urandom};
      exp[i] = model(qs[i][0], qs[i][1], qs[i][2], qs[i][3]);
    end
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 17; cyc++) begin
      bus_a.out_ready = (cyc >= 5);
      if (acc < 4) drive(1'b1, qs[acc][0], qs[acc][1], qs[acc][2], qs[acc][3]);
      else drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        tests_run++;
        if (bus_a.out_valid !== 1'b1 || bus_a.P !== exp[0]) begin
          tests_failed++; $display("FAIL bp_hold[%0d]: got v=%b P=%h want v=1 P=%h", cyc, bus_a.out_valid, bus_a.P, exp[0]);
        end
        tests_run++;
        if (bus_a.in_ready !== 1'b0) begin
          tests_failed++; $display("FAIL bp_in_ready[%0d]: got %b want 0", cyc, bus_a.in_ready);
        end
      end
      if (cyc == 4) begin
        tests_run++;
        if (acc != 2) begin
          tests_failed++; $display("FAIL bp_accepted: got %0d want 2", acc);
        end
      end
      if (bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
        tests_run++;
        if (got >= 4) begin
          tests_failed++; $display("FAIL bp_extra: got output %0d want at most 4", got + 1);
        end else if (bus_a.P !== exp[got] || bus_b.P !== exp[got]) begin
          tests_failed++; $display("FAIL bp_P[%0d]: got %h/%h want %h", got, bus_a.P, bus_b.P, exp[got]);
        end
        got++;
      end
      if (bus_a.in_valid === 1'b1 && bus_a.in_ready === 1'b1) acc++;
      tick();
    end
    tests_run++;
    if (got != 4 || acc != 4) begin
      tests_failed++; $display("FAIL bp_count: got %0d out %0d in want 4 and 4", got, acc);
    end
  endtask

  task automatic test_reset_midflight();
    bus_a.out_ready = 1'b1;
    drive(1'b1, 64'h1234, 64'h55, 64'h66, 64'h77);
    tick();
    drive(1'b1, 64'h9999, 64'hAA, 64'hBB, 64'hCC);
    tick();
    drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    tests_run++;
    if (bus_a.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre_valid: got %b want 1", bus_a.out_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0 || bus_a.P !== 128'd0 || bus_b.P !== 128'd0) begin
      tests_failed++; $display("FAIL mid_async: got v=%b/%b P=%h/%h want 0", bus_a.out_valid, bus_b.out_valid, bus_a.P, bus_b.P);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus_a.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_in_ready: got %b want 1", bus_a.in_ready);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      tests_run++;
      if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL mid_stale[%0d]: got %b/%b want 0", cyc, bus_a.out_valid, bus_b.out_valid);
      end
    end
    send_one("mid_identity", 64'd1, 64'd0, 64'd0, 64'd0, 128'd1);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_identity();
    test_mid_carry();
    test_max_operands();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
